// File: rtl/nios_v1_output_pio_if.sv
// Avalon-MM slave bus plus the output-word handshake toward ReCOP.
// The slave modport is the PIO's view; the master modport drives the bus and consumes the word.
interface nios_v1_output_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_port;
  logic        out_valid;
  logic        out_ack;

  modport slave (
    input  address, chipselect, write_n, writedata, out_ack,
    output readdata, out_port, out_valid
  );

  modport master (
    output address, chipselect, write_n, writedata, out_ack,
    input  readdata, out_port, out_valid
  );
endinterface

// File: rtl/nios_v1_output_pio.sv
// Nios II output PIO: registered 32-bit word to ReCOP with valid/ack handshake and sticky overrun.
// Define OUTPUT_PIO_BITSET_EN to implement the OUTSET/OUTCLEAR write ports.
module nios_v1_output_pio #(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  nios_v1_output_pio_if.slave     bus
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd1;
`ifdef OUTPUT_PIO_BITSET_EN
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
`endif

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] data_r;
  logic [31:0] data_next_s;
  logic [31:0] readdata_r;
  logic [31:0] rd_mux_s;
  logic        overrun_r;
  logic        overrun_set_s;
  logic        overrun_clr_s;
  logic        wr_s;
  logic        data_wr_s;
  logic        valid_s;

  assign wr_s    = bus.chipselect & ~bus.write_n;
  assign valid_s = (state_r == PENDING);

  // Data register next value; data_wr_s marks writes that present a new word
  always_comb begin
    data_next_s = data_r;
    data_wr_s   = 1'b0;
    if (wr_s) begin
      case (bus.address)
        ADDR_DATA: begin
          data_next_s = bus.writedata;
          data_wr_s   = 1'b1;
        end
`ifdef OUTPUT_PIO_BITSET_EN
        ADDR_OUTSET: begin
          data_next_s = data_r | bus.writedata;
          data_wr_s   = 1'b1;
        end
        ADDR_OUTCLEAR: begin
          data_next_s = data_r & ~bus.writedata;
          data_wr_s   = 1'b1;
        end
`endif
        default: begin
          data_next_s = data_r;
          data_wr_s   = 1'b0;
        end
      endcase
    end else begin
      data_next_s = data_r;
      data_wr_s   = 1'b0;
    end
  end

  // Handshake next state; an ack in the same cycle as a new word consumes the old one
  always_comb begin
    state_next_s  = state_r;
    overrun_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (data_wr_s) begin
          state_next_s = PENDING;
        end else begin
          state_next_s = IDLE;
        end
      end
      PENDING: begin
        if (data_wr_s) begin
          state_next_s  = PENDING;
          overrun_set_s = ~bus.out_ack;
        end else if (bus.out_ack) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = PENDING;
        end
      end
      default: begin
        state_next_s  = IDLE;
        overrun_set_s = 1'b0;
      end
    endcase
  end

  assign overrun_clr_s = wr_s && (bus.address == ADDR_STATUS) && bus.writedata[1];

  // Read mux, sampled every cycle regardless of chipselect
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (bus.address)
      ADDR_DATA:   rd_mux_s = data_r;
      ADDR_STATUS: rd_mux_s = {30'b0, overrun_r, valid_s};
      default:     rd_mux_s = 32'h0000_0000;
    endcase
  end

  // State, data, overrun and read data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      data_r     <= RESET_VALUE;
      overrun_r  <= 1'b0;
      readdata_r <= 32'h0000_0000;
    end else begin
      state_r    <= state_next_s;
      data_r     <= data_next_s;
      readdata_r <= rd_mux_s;
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end else if (overrun_clr_s) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign bus.out_port  = data_r;
  assign bus.out_valid = valid_s;
  assign bus.readdata  = readdata_r;

endmodule
